// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM state and op encodings for the serial arithmetic unit
package arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;
endpackage

// File: rtl/arith_unit_serial_if.sv
// arith_unit_serial_if: request/result handshake bundle for the serial arithmetic unit
interface arith_unit_serial_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] x, y, f;
  logic cin, sel0, sel1, in_valid, in_ready;
  logic cout, zero, ovf, out_valid, out_ready;
  modport master (output x, y, cin, sel0, sel1, in_valid, out_ready,
                  input f, cout, zero, ovf, out_valid, in_ready);
  modport slave (input x, y, cin, sel0, sel1, in_valid, out_ready,
                 output f, cout, zero, ovf, out_valid, in_ready);
endinterface

// File: rtl/arith_unit_serial_slice_adder.sv
// slice_adder: SLICE-bit adder exposing carry into and out of its top bit
module slice_adder #(parameter int SLICE = 8) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb_in
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + (SLICE+1)'(ci);
  // sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out of the sum
  assign c_msb_in = s[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];
endmodule

// File: rtl/arith_unit_serial.sv
// arith_unit_serial: slice-serial add/sub/inc/dec unit, SLICE bits per clock
module arith_unit_serial
  import arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic clk,
  input logic rst,
  arith_unit_serial_if.slave io
);
  localparam int NSLICE = WIDTH / (SLICE < 1 ? 1 : SLICE);
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  generate
    if (SLICE < 1 || SLICE > WIDTH || WIDTH % SLICE != 0) begin : g_bad_param
      $error("arith_unit_serial: SLICE must divide WIDTH and lie in 1..WIDTH");
    end
  endgenerate
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic carry, co, c_msb, cout, zero, ovf;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_n, f;
  logic [SLICE-1:0] s;
  logic [1:0] op;
  logic last;
  assign op = {io.sel1, io.sel0};
  assign last = idx == IW'(NSLICE - 1);
  // each new slice enters at the top; after NSLICE shifts the LSB slice sits at bit 0
  assign acc_n = WIDTH'({s, acc} >> SLICE);
  assign io.in_ready = state == IDLE;
  assign io.out_valid = state == DONE;
  assign io.f = f;
  assign io.cout = cout;
  assign io.zero = zero;
  assign io.ovf = ovf;
  slice_adder #(.SLICE(SLICE)) u_add (
    .a(a_sh[SLICE-1:0]), .b(b_sh[SLICE-1:0]), .ci(carry),
    .s(s), .co(co), .c_msb_in(c_msb)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = io.in_valid ? RUN : IDLE;
    else if (state == RUN) state_n = last ? DONE : RUN;
    else state_n = io.out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      carry <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      acc <= '0;
      f <= '0;
      cout <= 1'b0;
      zero <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && io.in_valid) begin
      idx <= '0;
      acc <= '0;
      a_sh <= io.x;
      b_sh <= op == OP_INC ? '0 : op == OP_ADD ? io.y : op == OP_SUB ? ~io.y : '1;
      carry <= op == OP_SUB ? ~io.cin : io.cin;
    end else if (state == RUN) begin
      idx <= idx + 1'b1;
      carry <= co;
      acc <= acc_n;
      a_sh <= a_sh >> SLICE;
      b_sh <= b_sh >> SLICE;
      if (last) begin
        f <= acc_n;
        cout <= co;
        ovf <= c_msb ^ co;
        zero <= acc_n == '0;
      end
    end
endmodule

// File: tb/tb_arith_unit_serial.sv
// tb_arith_unit_serial: directed vectors with hand-computed results for arith_unit_serial
module tb_arith_unit_serial;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  arith_unit_serial_if #(.WIDTH(32)) io ();
  arith_unit_serial #(.WIDTH(32), .SLICE(8)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic [31:0] ef, input logic ec, input logic ez,
                       input logic eo, input int hold);
    int n;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(io.in_ready), 32'd1);
    {io.sel1, io.sel0} = op;
    io.x = a;
    io.y = b;
    io.cin = ci;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    n = 0;
    while (!io.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".valid"}, 32'(io.out_valid), 32'd1);
    chk({tag, ".latency"}, 32'(n), 32'd4);
    chk({tag, ".f"}, io.f, ef);
    chk({tag, ".cout"}, 32'(io.cout), 32'(ec));
    chk({tag, ".zero"}, 32'(io.zero), 32'(ez));
    chk({tag, ".ovf"}, 32'(io.ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      io.in_valid = ~io.in_valid;
      io.x = ~io.x;
      io.y = io.y + 32'd3;
      @(posedge clk);
      #1;
      chk({tag, ".hold_f"}, io.f, ef);
      chk({tag, ".hold_valid"}, 32'(io.out_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(io.in_ready), 32'd0);
      chk({tag, ".hold_flags"}, 32'({io.cout, io.zero, io.ovf}), 32'({ec, ez, eo}));
    end
    @(negedge clk);
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    chk({tag, ".retire_valid"}, 32'(io.out_valid), 32'd0);
    chk({tag, ".retire_ready"}, 32'(io.in_ready), 32'd1);
    chk({tag, ".retire_f"}, io.f, ef);
  endtask

  initial begin
    rst = 1'b1;
    io.x = '0;
    io.y = '0;
    io.cin = 1'b0;
    io.sel0 = 1'b0;
    io.sel1 = 1'b0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(io.in_ready), 32'd1);
    chk("rst.out_valid", 32'(io.out_valid), 32'd0);
    chk("rst.f", io.f, 32'd0);
    chk("rst.flags", 32'({io.cout, io.zero, io.ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("add", 2'b01, 32'h4A, 32'h20, 1'b0, 32'h6A, 1'b0, 1'b0, 1'b0, 0);
    do_op("sub_c0", 2'b10, 32'h4A, 32'h20, 1'b0, 32'h2A, 1'b1, 1'b0, 1'b0, 0);
    do_op("sub_c1", 2'b10, 32'h4A, 32'h20, 1'b1, 32'h29, 1'b1, 1'b0, 1'b0, 0);
    do_op("dec0", 2'b11, 32'h0, 32'h1234, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0);
    do_op("inc_wrap", 2'b00, 32'hFFFFFFFF, 32'h55, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 0);
    do_op("add_ovf", 2'b01, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 0);
    do_op("add_slice", 2'b01, 32'hFF, 32'h1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 0);
    do_op("hold", 2'b01, 32'h4A, 32'h20, 1'b0, 32'h6A, 1'b0, 1'b0, 1'b0, 10);
    // reset two RUN edges into an operation
    @(negedge clk);
    {io.sel1, io.sel0} = 2'b01;
    io.x = 32'h11111111;
    io.y = 32'h22222222;
    io.cin = 1'b0;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.in_ready", 32'(io.in_ready), 32'd1);
    chk("midrst.out_valid", 32'(io.out_valid), 32'd0);
    chk("midrst.f", io.f, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("midrst.no_result", 32'(io.out_valid), 32'd0);
    end
    do_op("after_rst", 2'b10, 32'h5, 32'h7, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 0);
    do_op("inc_plain", 2'b00, 32'h5, 32'h0, 1'b0, 32'h5, 1'b0, 1'b0, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
